// File: rtl/bit_demux32_pkg.sv
// Shared types and constants for the 32-bit serial-to-parallel bit demux.
package bit_demux32_pkg;

   localparam int WORD_W = 32;
   localparam int IDX_W  = 5;

   localparam logic MODE_ADDR = 1'b0;
   localparam logic MODE_SEQ  = 1'b1;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/bit_demux32_dec5to32.sv
// 5-to-32 one-hot write-enable decoder; combinational, all zeros when en is low.
module dec5to32
   import bit_demux32_pkg::*;
(
   input  logic [IDX_W-1:0]  index,
   input  logic              en,
   output logic [WORD_W-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[index] = 1'b1;
   end

endmodule

// File: rtl/bit_demux32.sv
// Assembles serial bits into a 32-bit word (addressed or sequential fill); word_valid one cycle after completing bit.
// Stalls input (in_ready=0) while a completed word waits for word_ready; optional word_parity under BIT_DEMUX32_PARITY_EN.
module bit_demux32
   import bit_demux32_pkg::*;
#(
   parameter int unsigned CLEAR_ON_POP = 1
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              din,
   input  logic [IDX_W-1:0]  sel,
   input  logic              mode,
   output logic [WORD_W-1:0] Y,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [IDX_W-1:0]  idx
`ifdef BIT_DEMUX32_PARITY_EN
   ,
   output logic              word_parity
`endif
);

   state_t              state;
   logic [WORD_W-1:0]   mask;
   logic                mode_lat;
   logic                started;

   logic                accept;
   logic                pop;
   logic                cur_mode;
   logic                done;
   logic [IDX_W-1:0]    wr_idx;
   logic [WORD_W-1:0]   we;
   logic [WORD_W-1:0]   y_next;
   logic [WORD_W-1:0]   mask_next;

   assign in_ready   = (state == FILL);
   assign word_valid = (state == HOLD);
   assign accept     = in_valid & in_ready;
   assign pop        = word_valid & word_ready;

   // Mode is sampled only on the first bit of a word, then the latched copy rules.
   assign cur_mode  = started ? mode_lat : mode;
   assign wr_idx    = (cur_mode == MODE_SEQ) ? idx : sel;
   assign y_next    = (Y & ~we) | (we & {WORD_W{din}});
   assign mask_next = mask | we;
   assign done      = (cur_mode == MODE_SEQ) ? (idx == IDX_W'(WORD_W - 1)) : (&mask_next);

   dec5to32 u_dec (
      .index  (wr_idx),
      .en     (accept),
      .onehot (we)
   );

`ifdef BIT_DEMUX32_PARITY_EN
   logic par_q;
   assign word_parity = par_q & word_valid;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FILL;
         Y        <= '0;
         idx      <= '0;
         mask     <= '0;
         mode_lat <= MODE_ADDR;
         started  <= 1'b0;
`ifdef BIT_DEMUX32_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  Y        <= y_next;
                  mask     <= mask_next;
                  mode_lat <= cur_mode;
                  started  <= 1'b1;
                  if (cur_mode == MODE_SEQ) idx <= idx + IDX_W'(1);
                  if (done) begin
                     state <= HOLD;
`ifdef BIT_DEMUX32_PARITY_EN
                     par_q <= ^y_next;
`endif
                  end
               end
            end
            HOLD: begin
               if (pop) begin
                  state   <= FILL;
                  mask    <= '0;
                  idx     <= '0;
                  started <= 1'b0;
                  if (CLEAR_ON_POP != 0) Y <= '0;
`ifdef BIT_DEMUX32_PARITY_EN
                  par_q   <= 1'b0;
`endif
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_demux32.sv
// Directed bench for bit_demux32: driver pushes expected words, negedge monitor checks them on each pop.
module tb_bit_demux32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        din = 1'b0;
   logic [4:0]  sel = 5'd0;
   logic        mode = 1'b0;
   logic [31:0] Y;
   logic        word_valid;
   logic        word_ready = 1'b0;
   logic [4:0]  idx;
`ifdef BIT_DEMUX32_PARITY_EN
   logic        word_parity;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   always #5 clk = ~clk;

   bit_demux32 #(.CLEAR_ON_POP(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .din        (din),
      .sel        (sel),
      .mode       (mode),
      .Y          (Y),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .idx        (idx)
`ifdef BIT_DEMUX32_PARITY_EN
      ,
      .word_parity(word_parity)
`endif
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: compare Y against the oldest expected word at every pop.
   always @(negedge clk) begin
      if (rst_n && word_valid && word_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_pop", 32'd1, 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("sb_word", Y, mon_exp);
         end
      end
   end

   task automatic send_bit(input logic d, input logic [4:0] s, input logic m);
      int t;
      in_valid = 1'b1;
      din      = d;
      sel      = s;
      mode     = m;
      t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic pop_word();
      int t;
      word_ready = 1'b1;
      t = 0;
      while (!word_valid && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!word_valid) check("word_valid_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      word_ready = 1'b0;
   endtask

   task automatic seq_fill(input logic [31:0] pat);
      for (int i = 0; i < 32; i++) send_bit(pat[i], 5'd0, 1'b1);
   endtask

   initial begin : stim
      logic [31:0] pat;
      logic [4:0]  s;

      // Reset state, no clock edge needed
      #2;
      check("rst_Y", Y, 32'h0);
      check("rst_idx", {27'd0, idx}, 32'd0);
      check("rst_word_valid", {31'd0, word_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Sequential fill; mode toggles after the first bit and must be ignored
      pat = 32'hA5A5_0F0F;
      for (int i = 0; i < 32; i++) begin
         send_bit(pat[i], 5'd0, (i == 0) ? 1'b1 : i[0]);
         if (i == 30) begin
            check("seq_idx_31", {27'd0, idx}, 32'd31);
            check("seq_not_done", {31'd0, word_valid}, 32'd0);
         end
      end
      check("seq_word_valid", {31'd0, word_valid}, 32'd1);
      check("seq_Y", Y, 32'hA5A5_0F0F);
      check("seq_idx_wrap", {27'd0, idx}, 32'd0);
      exp_q.push_back(32'hA5A5_0F0F);
      pop_word();
      check("pop_clear_Y", Y, 32'h0);
      check("pop_in_ready", {31'd0, in_ready}, 32'd1);

      // Addressed fill, descending indices
      for (int i = 31; i >= 0; i--) begin
         s = 5'(i);
         send_bit(1'b1, s, 1'b0);
         if (i == 1) check("addr_not_done", {31'd0, word_valid}, 32'd0);
      end
      check("addr_done", {31'd0, word_valid}, 32'd1);
      check("addr_idx", {27'd0, idx}, 32'd0);
      exp_q.push_back(32'hFFFF_FFFF);
      pop_word();

      // Duplicate address; word_ready held high in FILL must not matter
      word_ready = 1'b1;
      send_bit(1'b1, 5'd5, 1'b0);
      send_bit(1'b0, 5'd5, 1'b0);
      check("dup_Y5", {31'd0, Y[5]}, 32'd0);
      for (int i = 0; i < 32; i++) begin
         if (i != 5) begin
            s = 5'(i);
            if (i == 31) check("dup_not_done", {31'd0, word_valid}, 32'd0);
            send_bit(1'b1, s, 1'b0);
         end
      end
      exp_q.push_back(32'hFFFF_FFDF);
      pop_word();

      // Backpressure: HOLD with in_valid asserted for 10 cycles
      seq_fill(32'h1234_5678);
      in_valid = 1'b1;
      din      = 1'b0;
      mode     = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_Y", Y, 32'h1234_5678);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      exp_q.push_back(32'h1234_5678);
      pop_word();
      check("bp_pop_Y", Y, 32'h0);
      check("bp_pop_in_ready", {31'd0, in_ready}, 32'd1);

      // Reset between clock edges after 17 sequential bits
      for (int i = 0; i < 17; i++) send_bit(1'b1, 5'd0, 1'b1);
      check("mid_idx_17", {27'd0, idx}, 32'd17);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_Y", Y, 32'h0);
      check("mid_rst_idx", {27'd0, idx}, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      #1 rst_n = 1'b1;
      seq_fill(32'h8000_0001);
      check("after_rst_Y", Y, 32'h8000_0001);
      exp_q.push_back(32'h8000_0001);
      pop_word();

`ifdef BIT_DEMUX32_PARITY_EN
      seq_fill(32'h0000_0007);
      check("parity_7", {31'd0, word_parity}, 32'd1);
      exp_q.push_back(32'h0000_0007);
      pop_word();
      seq_fill(32'h0000_0003);
      check("parity_3", {31'd0, word_parity}, 32'd0);
      exp_q.push_back(32'h0000_0003);
      pop_word();
`endif

      repeat (2) @(posedge clk);
      #1;
      check("sb_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bit_demux32.md
BIT_DEMUX32 -- requirements
Module: bit_demux32

Interface
REQ-001 SHALL have parameter CLEAR_ON_POP, default 1, meaning Y is zeroed when a completed word is popped (0: Y holds its last value).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, serial bit offered.
REQ-005 SHALL have port in_ready, output, 1, block accepts a bit this cycle.
REQ-006 SHALL have port din, input, 1, serial data bit.
REQ-007 SHALL have port sel, input, 5, destination bit index (addressed mode only).
REQ-008 SHALL have port mode, input, 1, word-fill mode: 0 = addressed, 1 = sequential auto-increment.
REQ-009 SHALL have port Y, output, 32, assembled word, registered.
REQ-010 SHALL have port word_valid, output, 1, Y is complete.
REQ-011 SHALL have port word_ready, input, 1, consumer takes Y.
REQ-012 SHALL have port idx, output, 5, current sequential write index.

Function
REQ-013 SHALL implement a two-state FSM: FILL (accepting bits) and HOLD (word complete, awaiting pop).
REQ-014 SHALL drive in_ready = 1 exactly in FILL and word_valid = 1 exactly in HOLD.
REQ-015 SHALL count a bit as accepted when in_valid & in_ready at a rising edge; Y updates at that same edge.
REQ-016 SHALL latch mode on the first accepted bit of each word and ignore mode for the rest of that word.
REQ-017 Sequential mode SHALL write din to Y[idx], then increment idx; sel is ignored.
REQ-018 Sequential mode SHALL move to HOLD at the edge that accepts the bit with idx = 31, with idx wrapping to 0.
REQ-019 Addressed mode SHALL write din to Y[sel] and set written-mask bit sel; all other Y bits hold.
REQ-020 Addressed mode SHALL move to HOLD at the edge at which the written mask becomes all-ones.
REQ-021 Repeated sel in addressed mode SHALL overwrite Y[sel] with no effect on the mask or the completion count.
REQ-022 word_valid SHALL assert in the cycle after the completing bit is accepted, i.e. one-cycle latency.
REQ-023 In HOLD, Y, idx and the mask SHALL be stable, and in_valid SHALL be ignored.
REQ-024 A pop SHALL occur when word_valid & word_ready at a rising edge.
REQ-025 On a pop the block SHALL return to FILL with mask = 0 and idx = 0, and Y SHALL be cleared if CLEAR_ON_POP = 1.
REQ-026 No bit SHALL be accepted in the pop cycle; in_ready rises the following cycle.
REQ-027 word_ready asserted in FILL SHALL have no effect.

Reset
REQ-028 SHALL, while rst_n = 0 and regardless of clk, force state = FILL, Y = 0, idx = 0, mask = 0, word_valid = 0 and in_ready = 1.
REQ-029 Reset asserted mid-word or in HOLD SHALL discard the partial or complete word with no pop indication.

Configuration
REQ-030 With macro BIT_DEMUX32_PARITY_EN defined, the block SHALL add output word_parity (1 bit) = XOR of all 32 Y bits, registered alongside word_valid and valid only in HOLD.
REQ-031 Without BIT_DEMUX32_PARITY_EN, port word_parity and its logic SHALL be absent.

Structure
REQ-032 A shared package SHALL hold the FSM state typedef (FILL, HOLD), the constants WORD_W = 32 and IDX_W = 5, and the mode encodings.
REQ-033 The 5-to-32 one-hot write-enable decoder SHALL be a sub-module named dec5to32 (input 5-bit index plus enable, output 32-bit one-hot), instantiated once.

Verification
REQ-034 Sequential fill: reset, then mode = 1 with 32 bits from pattern 0xA5A5_0F0F LSB first -> word_valid high the cycle after the 32nd bit, Y = 0xA5A5_0F0F, idx = 0.
REQ-035 Addressed fill, descending: mode = 0, sel 31..0, din = 1 -> Y = 0xFFFF_FFFF and word_valid only after sel = 0 is accepted.
REQ-036 Duplicate address: addressed mode, sel = 5 written 1 then 0, plus the other 31 indices written 1 -> word completes after 32 unique indices, Y = 0xFFFF_FFDF.
REQ-037 Backpressure: word_ready held 0 for 10 cycles in HOLD with in_valid = 1 -> Y unchanged and in_ready = 0; then pop -> with CLEAR_ON_POP = 1, Y = 0 and in_ready = 1 the next cycle.
REQ-038 Reset mid-word: rst_n pulsed low between clock edges after 17 sequential bits -> Y = 0 and idx = 0 immediately, and a new word starts at index 0.
REQ-039 Parity (BIT_DEMUX32_PARITY_EN defined): Y = 0x0000_0007 -> word_parity = 1; Y = 0x0000_0003 -> word_parity = 0.
